// File: rtl/lfsr_seq_ctrl.sv
// Sequencing controller for the 8-bit LFSR datapath: seeding, run/pause/single-step,
// step-rate prescaler and all-zero lockup recovery. All outputs are registered.
module lfsr_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             single_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [WIDTH-1:0] lfsr_q,
    output logic             lfsr_load,
    output logic [WIDTH-1:0] lfsr_seed,
    output logic             lfsr_step,
    output logic [1:0]       state_o,
    output logic             lockup,
    output logic [CNT_W-1:0] step_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        RECOVER = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] SEED_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t             state, state_n;
    state_t             prev_state, prev_state_n;
    logic [DIV_W-1:0]   div_reg, div_reg_n;
    logic [DIV_W-1:0]   presc, presc_n;
    logic               single_q;
    logic               load_d;
    logic               load_n, step_n, lockup_n;
    logic [WIDTH-1:0]   seed_n;
    logic [CNT_W-1:0]   cnt_n;
    logic               single_rise;
    logic               lock_det;

    assign single_rise = single_i & ~single_q;

    // lfsr_q only reflects a load one cycle after the strobe, so both the strobe
    // cycle and the one after it are excluded from the all-zero check.
    assign lock_det = ((state == RUN) || (state == PAUSE)) && (lfsr_q == '0)
                      && !lfsr_load && !load_d && !load_i;

    always_comb begin
        state_n      = state;
        prev_state_n = prev_state;
        div_reg_n    = div_reg;
        presc_n      = presc;
        load_n       = 1'b0;
        step_n       = 1'b0;
        seed_n       = lfsr_seed;
        lockup_n     = lockup;
        cnt_n        = step_cnt;

        if (state == RECOVER) begin
            state_n = prev_state;
        end else if (load_i) begin
            seed_n   = (seed_i == '0) ? SEED_ONE : seed_i;
            load_n   = 1'b1;
            cnt_n    = '0;
            lockup_n = 1'b0;
            presc_n  = div_reg;
        end else if (lock_det) begin
            prev_state_n = state;
            state_n      = RECOVER;
            lockup_n     = 1'b1;
            load_n       = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (stop_i) begin
                        state_n = IDLE;
                    end else if (single_rise) begin
                        step_n = 1'b1;
                    end else if (start_i) begin
                        state_n   = RUN;
                        div_reg_n = div_i;
                        presc_n   = div_i;
                    end
                end
                RUN: begin
                    if (stop_i) begin
                        state_n = PAUSE;
                    end else if (presc == '0) begin
                        step_n  = 1'b1;
                        presc_n = div_reg;
                    end else begin
                        presc_n = presc - DIV_W'(1);
                    end
                end
                PAUSE: begin
                    if (stop_i) begin
                        state_n = PAUSE;
                    end else if (single_rise) begin
                        step_n = 1'b1;
                    end else if (start_i) begin
                        state_n = RUN;
                    end
                end
                default: state_n = state;
            endcase
        end

        if (step_n) begin
            cnt_n = step_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            prev_state <= IDLE;
            div_reg    <= '0;
            presc      <= '0;
            single_q   <= 1'b0;
            load_d     <= 1'b0;
            lfsr_load  <= 1'b0;
            lfsr_step  <= 1'b0;
            lfsr_seed  <= SEED_ONE;
            lockup     <= 1'b0;
            step_cnt   <= '0;
        end else if (ena) begin
            state      <= state_n;
            prev_state <= prev_state_n;
            div_reg    <= div_reg_n;
            presc      <= presc_n;
            single_q   <= single_i;
            load_d     <= lfsr_load;
            lfsr_load  <= load_n;
            lfsr_step  <= step_n;
            lfsr_seed  <= seed_n;
            lockup     <= lockup_n;
            step_cnt   <= cnt_n;
        end else begin
            lfsr_load <= 1'b0;
            lfsr_step <= 1'b0;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: directed scenarios followed by randomized traffic, every cycle
// checked against a behavioural model of the sequencing rules.
module tb_lfsr_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, ena, start_i, stop_i, single_i, load_i;
    logic [7:0]  seed_i, lfsr_q;
    logic [15:0] div_i;
    logic        lfsr_load, lfsr_step, lockup;
    logic [7:0]  lfsr_seed;
    logic [1:0]  state_o;
    logic [15:0] step_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int steps_seen = 0;

    // model: states 0 idle, 1 run, 2 pause, 3 recover; elapsed = cycles into current interval
    int m_state, m_prev, m_div, m_elapsed, m_seed, m_cnt;
    bit m_single, m_lock, m_load, m_step, m_load_prev;

    always #5 clk = ~clk;

    lfsr_seq_ctrl #(.WIDTH(8), .DIV_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start_i(start_i), .stop_i(stop_i),
        .single_i(single_i), .load_i(load_i), .seed_i(seed_i), .div_i(div_i),
        .lfsr_q(lfsr_q), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed),
        .lfsr_step(lfsr_step), .state_o(state_o), .lockup(lockup), .step_cnt(step_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit rise, ld_recent;
        int req;
        if (!rst_n) begin
            m_state = 0; m_prev = 0; m_div = 0; m_elapsed = 0; m_seed = 1; m_cnt = 0;
            m_single = 0; m_lock = 0; m_load = 0; m_step = 0; m_load_prev = 0;
            return;
        end
        if (!ena) begin
            m_load = 0; m_step = 0;
            return;
        end
        rise = single_i && !m_single;
        m_single = single_i;
        ld_recent = m_load || m_load_prev;
        m_load_prev = m_load;
        m_load = 0; m_step = 0;
        if (m_state == 3) begin
            m_state = m_prev;
        end else if (load_i) begin
            m_seed = (seed_i == 8'd0) ? 1 : int'(seed_i);
            m_load = 1; m_cnt = 0; m_lock = 0; m_elapsed = 0;
        end else if ((m_state == 1 || m_state == 2) && lfsr_q == 8'd0 && !ld_recent) begin
            m_prev = m_state; m_state = 3; m_lock = 1; m_load = 1;
        end else begin
            req = stop_i ? 1 : (rise ? 2 : (start_i ? 3 : 0));
            case (m_state)
                0: if (req == 2) m_step = 1;
                   else if (req == 3) begin m_state = 1; m_div = int'(div_i); m_elapsed = 0; end
                1: if (req == 1) m_state = 2;
                   else if (m_elapsed == m_div) begin m_step = 1; m_elapsed = 0; end
                   else m_elapsed++;
                2: if (req == 2) m_step = 1;
                   else if (req == 3) m_state = 1;
                default: ;
            endcase
        end
        if (m_step) m_cnt = (m_cnt + 1) % 65536;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        if (lfsr_step === 1'b1) steps_seen++;
        check("state", 32'(state_o), m_state);
        check("load", 32'(lfsr_load), 32'(m_load));
        check("step", 32'(lfsr_step), 32'(m_step));
        check("seed", 32'(lfsr_seed), m_seed);
        check("lockup", 32'(lockup), 32'(m_lock));
        check("cnt", 32'(step_cnt), m_cnt);
        check("excl", 32'(lfsr_load & lfsr_step), 0);
    endtask

    task automatic quiet();
        rst_n = 1; ena = 1; start_i = 0; stop_i = 0; single_i = 0; load_i = 0;
        seed_i = 8'h00; div_i = 16'd0; lfsr_q = 8'h5A;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int cnt_frozen;
        quiet();
        rst_n = 0;
        cycle();
        check("rst_state", 32'(state_o), 0);
        check("rst_seed", 32'(lfsr_seed), 1);
        rst_n = 1;
        run_cycles(2);

        // seed path
        load_i = 1; seed_i = 8'hA5;
        cycle();
        check("seed_load", 32'(lfsr_load), 1);
        check("seed_val", 32'(lfsr_seed), 32'h A5);
        check("seed_cnt", 32'(step_cnt), 0);
        quiet();
        cycle();
        check("seed_once", 32'(lfsr_load), 0);

        // prescaler div=3
        start_i = 1; div_i = 16'd3;
        cycle();
        quiet();
        steps_seen = 0;
        run_cycles(40);
        check("div3_cnt", 32'(step_cnt), 10);
        check("div3_seen", steps_seen, 10);

        // pause, single-step, resume
        stop_i = 1;
        cycle();
        quiet();
        check("pause_state", 32'(state_o), 2);
        steps_seen = 0;
        run_cycles(20);
        check("pause_quiet", steps_seen, 0);
        single_i = 1;
        steps_seen = 0;
        run_cycles(5);
        check("single_once", steps_seen, 1);
        quiet();
        run_cycles(2);
        start_i = 1;
        cycle();
        quiet();
        run_cycles(9);

        // div=0 steps every cycle
        rst_n = 0;
        cycle();
        quiet();
        start_i = 1; div_i = 16'd0;
        cycle();
        quiet();
        steps_seen = 0;
        run_cycles(10);
        check("div0_seen", steps_seen, 10);

        // zero seed then lockup recovery in RUN
        load_i = 1; seed_i = 8'h00;
        cycle();
        check("zero_seed", 32'(lfsr_seed), 1);
        quiet();
        run_cycles(3);
        lfsr_q = 8'h00;
        cycle();
        lfsr_q = 8'h5A;
        check("lk_state", 32'(state_o), 3);
        check("lk_flag", 32'(lockup), 1);
        check("lk_load", 32'(lfsr_load), 1);
        check("lk_nostep", 32'(lfsr_step), 0);
        cycle();
        check("lk_back", 32'(state_o), 1);
        run_cycles(3);

        // priority
        load_i = 1; stop_i = 1; start_i = 1; seed_i = 8'h3C;
        cycle();
        check("pri_state", 32'(state_o), 1);
        check("pri_load", 32'(lfsr_load), 1);
        quiet();
        run_cycles(2);
        stop_i = 1; start_i = 1;
        cycle();
        check("pri_stop", 32'(state_o), 2);
        quiet();

        // reset mid-run
        start_i = 1; div_i = 16'd1;
        cycle();
        quiet();
        run_cycles(5);
        rst_n = 0;
        cycle();
        check("mrst_state", 32'(state_o), 0);
        check("mrst_cnt", 32'(step_cnt), 0);
        check("mrst_strb", 32'({lfsr_load, lfsr_step}), 0);
        quiet();

        // enable low in RUN
        start_i = 1; div_i = 16'd0;
        cycle();
        quiet();
        run_cycles(3);
        cnt_frozen = int'(step_cnt);
        ena = 0;
        steps_seen = 0;
        run_cycles(10);
        check("ena_cnt", 32'(step_cnt), cnt_frozen);
        check("ena_strb", steps_seen, 0);
        ena = 1;
        run_cycles(3);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            ena      = ($urandom_range(0, 19) != 0);
            load_i   = ($urandom_range(0, 29) == 0);
            stop_i   = ($urandom_range(0, 19) == 0);
            start_i  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) single_i = ~single_i;
            seed_i   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            div_i    = 16'($urandom_range(0, 5));
            lfsr_q   = ($urandom_range(0, 14) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lfsr_seq_ctrl.md
Name: lfsr_seq_ctrl

Overview:
Sequencing controller for the 8-bit LFSR datapath in the tt_um_sahrdayalfsr top level.
- Owns seeding, run/pause/single-step control and the step-rate prescaler.
- Detects the all-zero lockup state and recovers from it.
- Sits between the user-input decode (ui_in) and the LFSR core. The core shifts only when lfsr_step=1 and loads only when lfsr_load=1.

Parameters:
WIDTH, 8, LFSR/seed width
DIV_W, 16, prescaler width
CNT_W, 16, step counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
ena  in  1  design enable; 0 freezes FSM, prescaler and counter, and forces lfsr_step=0 and lfsr_load=0
start_i  in  1  run request, level-sampled each cycle
stop_i  in  1  pause request
single_i  in  1  one-step request, rising-edge detected
load_i  in  1  seed-load request
seed_i  in  WIDTH  seed, sampled when load_i=1
div_i  in  DIV_W  step interval, sampled when start_i is accepted
lfsr_q  in  WIDTH  current LFSR register value from the datapath
lfsr_load  out  1  one-cycle load strobe to the LFSR
lfsr_seed  out  WIDTH  value to load; held stable
lfsr_step  out  1  one-cycle shift strobe to the LFSR
state_o  out  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 RECOVER
lockup  out  1  sticky all-zero-detected flag
step_cnt  out  CNT_W  number of steps issued since the last load

Behaviour:
Reset (rst_n=0 at a clk edge):
- state=IDLE, lfsr_load=0, lfsr_step=0, lockup=0, step_cnt=0.
- lfsr_seed=1 (WIDTH'b1), prescaler=0, div_reg=0, single edge register=0.

Outputs: all outputs are registered, with no combinational path from inputs to outputs.

Command arbitration (ena=1), priority load > stop > single > start:
- Only the highest-priority request is acted on in a cycle. Lower-priority requests in the same cycle are dropped, not queued.
- single_i edge register updates every ena=1 cycle regardless of arbitration.

load_i (any state except RECOVER):
- lfsr_seed <= (seed_i==0) ? 1 : seed_i.
- lfsr_load=1 for exactly one cycle, the cycle after the request.
- step_cnt <= 0, lockup <= 0, prescaler reloaded with div_reg.
- State unchanged.
- During RECOVER, load_i is ignored.

FSM:
- IDLE: start_i goes to RUN, with div_reg <= div_i and prescaler <= div_i. single_i rising edge issues one step and stays in IDLE.
- RUN:
  - prescaler counts down by 1 per cycle.
  - At 0: lfsr_step=1 next cycle, prescaler <= div_reg.
  - Step interval is div_reg+1 cycles; div_reg=0 steps every cycle.
  - stop_i goes to PAUSE.
  - start_i while in RUN is ignored; div_reg is not resampled.
- PAUSE: prescaler holds its value. start_i returns to RUN, resuming the countdown without reloading div. single_i rising edge issues one step.
- RECOVER: entered from RUN or PAUSE (see lockup below). Stays one cycle, then returns to the state it came from (prev_state register).

Single-step:
- One lfsr_step per 0→1 transition of single_i; holding single_i high gives only one step.
- single_i is ignored in RUN.

Lockup:
- Condition: lfsr_q==0 in RUN or PAUSE, no lfsr_load pending or asserted this cycle or the previous cycle.
- Action: go to RECOVER, lockup <= 1, lfsr_load=1 with the current lfsr_seed (never 0 by construction).
- No lfsr_step is issued in the RECOVER cycle, and the prescaler holds.
- step_cnt is not cleared.

step_cnt:
- +1 on every cycle with lfsr_step=1.
- Wraps from 2^CNT_W-1 to 0.
- Cleared only by load or reset.

Simultaneous events:
- A prescaler expiry coinciding with load: the load wins, no step that cycle, prescaler reloaded.
- A prescaler expiry coinciding with stop: no step is issued.
- lfsr_load and lfsr_step are never 1 in the same cycle.

Reset mid-run: next cycle matches the reset state exactly; no stray strobes.

ena=0: all registers hold, and both strobes are 0. Requests presented while ena=0 are lost.

Test Plan:
- Seed path: reset; load_i=1 with seed_i=8'hA5 for 1 cycle → lfsr_load=1 one cycle later with lfsr_seed=8'hA5, step_cnt=0, state_o=0.
- Prescaler: start_i with div_i=3 → lfsr_step pulses every 4 cycles; after 40 cycles step_cnt=10; div_i=0 gives a step every cycle.
- Pause and single-step:
  - stop_i during RUN → state_o=2 and no steps for 20 cycles.
  - single_i held high 5 cycles → exactly 1 step.
  - start_i → resumes from the held prescaler value.
- Zero seed and lockup:
  - load seed_i=0 → lfsr_seed=8'h01.
  - Force lfsr_q=0 in RUN → state_o=3 for 1 cycle, lockup=1, lfsr_load=1, no step in that cycle, then back to state_o=1.
- Priority:
  - load_i, stop_i and start_i together in RUN → load only, state stays RUN.
  - stop+start together → PAUSE.
  - Check lfsr_load & lfsr_step never both 1 throughout.
- Reset and enable: rst_n=0 mid-RUN for 1 cycle → all outputs at reset values next cycle; ena=0 for 10 cycles in RUN → step_cnt frozen, strobes 0.
